// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0004;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/perf_counters.sv
// 64-bit cycle and retired-instruction counters with per-counter increment enables.
module perf_counters
    import core_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        cycle_en_i,
    input  logic        instret_en_i,
    output logic [63:0] cycle_count_o,
    output logic [63:0] instret_count_o
);

    logic [63:0] cycle_q;
    logic [63:0] cycle_d;
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    // Next-count selection; both counters wrap naturally mod 2^64.
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (cycle_en_i) begin
            cycle_d = cycle_q + 64'd1;
        end else begin
            cycle_d = cycle_q;
        end
        if (instret_en_i) begin
            instret_d = instret_q + 64'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count_o   = cycle_q;
    assign instret_count_o = instret_q;

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage sequencer: owns the PC, qualifies the fetched word, handles
// redirects, halt/trap detection and the performance counters.
module program_counter_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] mechine_code,
    output logic [31:0] mem_adress,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_addr,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
);

    // One bit wider than the PC so a 4 GiB memory limit does not overflow.
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  trap_addr_q;
    logic [31:0]  trap_addr_d;
    logic         halted_q;
    logic         trap_q;
    logic         in_range_s;
    logic         is_halt_s;
    logic         instr_valid_s;
    logic [31:0]  pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign in_range_s = ({1'b0, pc_q} < IMEM_LIMIT);
    assign is_halt_s  = (mechine_code == HALT_WORD) || !in_range_s;

    // State, PC and trap-address registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            trap_addr_q <= 32'd0;
            halted_q    <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_addr_q <= trap_addr_d;
            halted_q    <= (state_d == HALT);
            trap_q      <= (state_d == TRAP);
        end
    end

    // Next state and next PC; stall beats halt beats redirect beats sequential.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (is_halt_s) begin
                    state_d = HALT;
                end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                    state_d     = TRAP;
                    trap_addr_d = redirect_target;
                end else if (redirect_valid) begin
                    pc_d = {redirect_target[31:2], 2'b00};
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            HALT: state_d = HALT;
            TRAP: state_d = TRAP;
            // Unreachable encoding: park in TRAP rather than fetch from a suspect PC.
            default: state_d = TRAP;
        endcase
    end

    // Retirement qualification and instruction forwarding to decode.
    always_comb begin
        instr_valid_s = (state_q == RUN) && !stall && !is_halt_s;
        if (instr_valid_s) begin
            instr_out = mechine_code;
        end else begin
            instr_out = NOP_INSTR;
        end
    end

    perf_counters u_perf_counters (
        .clock           (clock),
        .reset           (reset),
        .cycle_en_i      (1'b1),
        .instret_en_i    (instr_valid_s),
        .cycle_count_o   (cycle_count),
        .instret_count_o (instret_count)
    );

    assign mem_adress  = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign instr_valid = instr_valid_s;
    assign halted      = halted_q;
    assign trap        = trap_q;
    assign trap_addr   = trap_addr_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit.
module tb_program_counter_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] mechine_code;
    logic [31:0] mem_adress, pc_plus4, instr_out, trap_addr;
    logic        instr_valid, halted, trap;
    logic [63:0] cycle_count, instret_count;

    // Second instance with a 4-word memory for the out-of-range test.
    logic [31:0] s_code;
    logic [31:0] s_adress, s_plus4, s_instr, s_trap_addr;
    logic        s_valid, s_halted, s_trap;
    logic [63:0] s_cycle, s_instret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];

    localparam logic [31:0] NOP = 32'h0000_0013;

    program_counter_unit dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mechine_code(mechine_code), .mem_adress(mem_adress), .pc_plus4(pc_plus4),
        .instr_out(instr_out), .instr_valid(instr_valid), .halted(halted), .trap(trap),
        .trap_addr(trap_addr), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    program_counter_unit #(.IMEM_WORDS(4)) dut_small (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mechine_code(s_code), .mem_adress(s_adress), .pc_plus4(s_plus4),
        .instr_out(s_instr), .instr_valid(s_valid), .halted(s_halted), .trap(s_trap),
        .trap_addr(s_trap_addr), .cycle_count(s_cycle), .instret_count(s_instret)
    );

    always #5 clock = ~clock;

    // Combinational instruction memory models.
    always_comb begin
        if (mem_adress < 32'd256) mechine_code = mem[mem_adress[7:2]];
        else                      mechine_code = 32'hDEAD_0001;
        s_code = 32'hA000_0000 | s_adress;
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'd0;
        mem[10] = 32'd0;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_adress !== 32'd4) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", mem_adress, 32'd4); end
        n_checks++; if (pc_plus4 !== 32'd8) begin n_fail++; $display("FAIL reset_pc_plus4: got %h exp %h", pc_plus4, 32'd8); end
        n_checks++; if (halted !== 1'b0 || trap !== 1'b0) begin n_fail++; $display("FAIL reset_state: halted %b trap %b exp 0 0", halted, trap); end
        n_checks++; if (cycle_count !== 64'd0 || instret_count !== 64'd0) begin n_fail++; $display("FAIL reset_counters: cyc %0d ret %0d exp 0 0", cycle_count, instret_count); end
        n_checks++; if (trap_addr !== 32'd0) begin n_fail++; $display("FAIL reset_trap_addr: got %h exp 0", trap_addr); end
        n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0001) begin n_fail++; $display("FAIL reset_first_instr: valid %b instr %h exp 1 10000001", instr_valid, instr_out); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            n_checks++; if (mem_adress !== 32'(4*i) || instr_valid !== 1'b1 || instr_out !== 32'h1000_0000 + 32'(i)) begin
                n_fail++; $display("FAIL seq_fetch_%0d: pc %h valid %b instr %h exp pc %h valid 1", i, mem_adress, instr_valid, instr_out, 32'(4*i));
            end
            step();
        end
        n_checks++; if (mem_adress !== 32'd40 || instr_valid !== 1'b0 || instr_out !== NOP) begin n_fail++; $display("FAIL seq_halt_word: pc %h valid %b instr %h exp 28 0 NOP", mem_adress, instr_valid, instr_out); end
        step();
        n_checks++; if (halted !== 1'b1 || instret_count !== 64'd9 || mem_adress !== 32'd40) begin n_fail++; $display("FAIL seq_halted: halted %b ret %0d pc %h exp 1 9 28", halted, instret_count, mem_adress); end
        step(); step();
        n_checks++; if (mem_adress !== 32'd40 || cycle_count !== 64'd12 || instret_count !== 64'd9 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL seq_frozen: pc %h cyc %0d ret %0d valid %b exp 28 12 9 0", mem_adress, cycle_count, instret_count, instr_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step();
        n_checks++; if (mem_adress !== 32'd12) begin n_fail++; $display("FAIL redir_pre_pc: got %h exp c", mem_adress); end
        redirect_valid = 1'b1; redirect_target = 32'h0000_0008;
        #1;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_retire: got %b exp 1", instr_valid); end
        step();
        redirect_valid = 1'b0;
        n_checks++; if (mem_adress !== 32'd8 || pc_plus4 !== 32'd12) begin n_fail++; $display("FAIL redir_target: pc %h plus4 %h exp 8 c", mem_adress, pc_plus4); end
        n_checks++; if (instret_count !== 64'd3 || cycle_count !== 64'd3) begin n_fail++; $display("FAIL redir_counts: ret %0d cyc %0d exp 3 3", instret_count, cycle_count); end
        step();
        n_checks++; if (mem_adress !== 32'd12 || instret_count !== 64'd4) begin n_fail++; $display("FAIL redir_resume: pc %h ret %0d exp c 4", mem_adress, instret_count); end
    endtask

    task automatic test_misaligned();
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0006;
        #1;
        n_checks++; if (mem_adress !== 32'd8 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL mis_retire: pc %h valid %b exp 8 1", mem_adress, instr_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (trap !== 1'b1 || halted !== 1'b0 || trap_addr !== 32'd6) begin n_fail++; $display("FAIL mis_trap: trap %b halted %b addr %h exp 1 0 6", trap, halted, trap_addr); end
        n_checks++; if (mem_adress !== 32'd8 || instr_valid !== 1'b0 || instr_out !== NOP || instret_count !== 64'd2) begin
            n_fail++; $display("FAIL mis_frozen: pc %h valid %b instr %h ret %0d exp 8 0 NOP 2", mem_adress, instr_valid, instr_out, instret_count);
        end
        step();
        n_checks++; if (cycle_count !== 64'd3 || mem_adress !== 32'd8 || instret_count !== 64'd2) begin n_fail++; $display("FAIL mis_cycles: cyc %0d pc %h ret %0d exp 3 8 2", cycle_count, mem_adress, instret_count); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (mem_adress !== 32'd16 || instr_out !== NOP || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold_%0d: pc %h instr %h valid %b exp 10 NOP 0", i, mem_adress, instr_out, instr_valid);
            end
            step();
        end
        n_checks++; if (mem_adress !== 32'd16 || instret_count !== 64'd3 || cycle_count !== 64'd6) begin n_fail++; $display("FAIL stall_counts: pc %h ret %0d cyc %0d exp 10 3 6", mem_adress, instret_count, cycle_count); end
        stall = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b exp 1", instr_valid); end
        step();
        redirect_valid = 1'b0;
        n_checks++; if (mem_adress !== 32'd32 || instret_count !== 64'd4) begin n_fail++; $display("FAIL stall_redirect: pc %h ret %0d exp 20 4", mem_adress, instret_count); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        step(); step();
        n_checks++; if (s_adress !== 32'd12 || s_valid !== 1'b1) begin n_fail++; $display("FAIL oor_last: pc %h valid %b exp c 1", s_adress, s_valid); end
        step();
        n_checks++; if (s_adress !== 32'd16 || s_valid !== 1'b0 || s_code === 32'd0) begin n_fail++; $display("FAIL oor_block: pc %h valid %b code %h exp 10 0 nonzero", s_adress, s_valid, s_code); end
        step();
        n_checks++; if (s_halted !== 1'b1 || s_adress !== 32'd16 || s_instret !== 64'd3) begin n_fail++; $display("FAIL oor_halted: halted %b pc %h ret %0d exp 1 10 3", s_halted, s_adress, s_instret); end
    endtask

    task automatic check_after_reset(input string tag);
        n_checks++; if (mem_adress !== 32'd4 || halted !== 1'b0 || trap !== 1'b0 || cycle_count !== 64'd0 || instret_count !== 64'd0 || trap_addr !== 32'd0) begin
            n_fail++; $display("FAIL %s: pc %h halted %b trap %b cyc %0d ret %0d addr %h exp 4 0 0 0 0 0", tag, mem_adress, halted, trap, cycle_count, instret_count, trap_addr);
        end
    endtask

    task automatic test_reset_in_halt_trap();
        do_reset();
        for (int i = 0; i < 11; i++) step();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rst_halt_setup: halted %b exp 1", halted); end
        do_reset();
        check_after_reset("rst_from_halt");
        step();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0006;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (trap !== 1'b1) begin n_fail++; $display("FAIL rst_trap_setup: trap %b exp 1", trap); end
        do_reset();
        check_after_reset("rst_from_trap");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_misaligned();
        test_stall();
        test_out_of_range();
        test_reset_in_halt_trap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
